// File: rtl/score_manager.sv
// Score accumulator for a bubble-shooter round: popped bubbles queue up as pending
// points that drain one per clock into a 4-digit BCD score shown on a tile row.
module score_manager #(
    parameter logic [15:0] TARGET_BCD = 16'h0050,
    parameter logic [4:0]  DARK_IDX   = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        game_over,
    input  logic        pop_valid,
    input  logic [3:0]  pop_cnt,
    output logic [39:0] Row1,
    output logic        score_achieve,
    output logic [15:0] score_bcd,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [5:0]  r_pending;
    logic [5:0]  w_pending_next;
    logic [15:0] r_score;
    logic [15:0] w_score_next;
    logic        r_achieve;
    logic        w_achieve_next;
    logic [39:0] r_row;
    logic [6:0]  w_pend_sum;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return res;
    endfunction

    // Digits are blanked while they and every more-significant digit are zero.
    function automatic logic [39:0] row_of(input logic [15:0] s);
        logic [4:0] th;
        logic [4:0] hu;
        logic [4:0] te;
        logic [4:0] on;
        th = (s[15:12] == 4'd0) ? DARK_IDX : {1'b0, s[15:12]};
        hu = (s[15:8]  == 8'd0) ? DARK_IDX : {1'b0, s[11:8]};
        te = (s[15:4]  == 12'd0) ? DARK_IDX : {1'b0, s[7:4]};
        on = {1'b0, s[3:0]};
        return {DARK_IDX, DARK_IDX, th, hu, te, on, DARK_IDX, DARK_IDX};
    endfunction

    assign w_pend_sum = {1'b0, r_pending}
                      - ((r_pending != 6'd0) ? 7'd1 : 7'd0)
                      + (pop_valid ? {3'd0, pop_cnt} : 7'd0);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_score_next   = r_score;
        w_achieve_next = r_achieve;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_RUN;
                    w_score_next   = 16'h0000;
                    w_pending_next = 6'd0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if ((r_pending != 6'd0) && (r_score != TARGET_BCD) && (r_score != 16'h9999)) begin
                    w_score_next = bcd_inc(r_score);
                end else begin
                    w_score_next = r_score;
                end
                // Reaching the target wins even if the field filled on the same cycle.
                if (r_score == TARGET_BCD) begin
                    w_state_next   = S_DONE;
                    w_achieve_next = 1'b1;
                    w_pending_next = 6'd0;
                end else if (game_over) begin
                    w_state_next   = S_DONE;
                    w_achieve_next = 1'b0;
                    w_pending_next = 6'd0;
                end else begin
                    w_pending_next = (w_pend_sum > 7'd63) ? 6'd63 : w_pend_sum[5:0];
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_next   = S_IDLE;
                    w_achieve_next = 1'b0;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_pending_next = 6'd0;
                w_score_next   = 16'h0000;
                w_achieve_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= 6'd0;
            r_score   <= 16'h0000;
            r_achieve <= 1'b0;
            r_row     <= {{5{DARK_IDX}}, 5'd0, {2{DARK_IDX}}};
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_score   <= w_score_next;
            r_achieve <= w_achieve_next;
            r_row     <= row_of(r_score);
        end
    end

    assign Row1          = r_row;
    assign score_achieve = r_achieve;
    assign score_bcd     = r_score;
    assign busy          = (r_pending != 6'd0);

endmodule

// File: tb/tb_score_manager.sv
// Directed bench for score_manager: expected scores are queued as pops are issued and
// compared edge by edge; a second instance with an unreachable target covers saturation.
module tb_score_manager;

    logic        clk = 1'b0;
    logic        rst, start, game_over, pop_valid;
    logic [3:0]  pop_cnt;
    logic [39:0] Row1;
    logic        score_achieve, busy;
    logic [15:0] score_bcd;

    logic        b_rst, b_start, b_game_over, b_pop_valid;
    logic [3:0]  b_pop_cnt;
    logic [39:0] b_Row1;
    logic        b_score_achieve, b_busy;
    logic [15:0] b_score_bcd;

    int n_cmp  = 0;
    int n_fail = 0;
    int cur    = 0;
    logic [15:0] exp_q[$];

    localparam logic [4:0] DK = 5'd31;

    always #5 clk = ~clk;

    score_manager u_dut (
        .clk(clk), .rst(rst), .start(start), .game_over(game_over),
        .pop_valid(pop_valid), .pop_cnt(pop_cnt), .Row1(Row1),
        .score_achieve(score_achieve), .score_bcd(score_bcd), .busy(busy)
    );

    score_manager #(.TARGET_BCD(16'hFFFF), .DARK_IDX(5'd31)) u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .game_over(b_game_over),
        .pop_valid(b_pop_valid), .pop_cnt(b_pop_cnt), .Row1(b_Row1),
        .score_achieve(b_score_achieve), .score_bcd(b_score_bcd), .busy(b_busy)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [39:0] row_exp(input int v);
        logic [4:0] th, hu, te, on;
        th = (v < 1000) ? DK : 5'((v / 1000) % 10);
        hu = (v < 100)  ? DK : 5'((v / 100) % 10);
        te = (v < 10)   ? DK : 5'((v / 10) % 10);
        on = 5'(v % 10);
        return {DK, DK, th, hu, te, on, DK, DK};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one pop of k, queue the expected score for each draining edge, then compare.
    task automatic drain(input int k, input bit chk_row);
        logic [15:0] e;
        pop_valid = 1'b1;
        pop_cnt   = 4'(k);
        tick();
        pop_valid = 1'b0;
        pop_cnt   = 4'd0;
        check("busy_after_pop", 64'(busy), 64'(k != 0));
        check("score_at_pop", 64'(score_bcd), 64'(to_bcd(cur)));
        for (int i = 1; i <= k; i++) exp_q.push_back(to_bcd(cur + i));
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check("score_drain", 64'(score_bcd), 64'(e));
        end
        cur = cur + k;
        check("busy_drained", 64'(busy), 64'd0);
        if (chk_row) begin
            tick();
            check("row_after_drain", 64'(Row1), 64'(row_exp(cur)));
        end
    endtask

    initial begin
        int          guard;
        logic [15:0] e;
        rst = 1'b1; start = 1'b0; game_over = 1'b0; pop_valid = 1'b0; pop_cnt = 4'd0;
        b_rst = 1'b1; b_start = 1'b0; b_game_over = 1'b0; b_pop_valid = 1'b0; b_pop_cnt = 4'd0;
        repeat (2) tick();
        check("rst_score", 64'(score_bcd), 64'h0);
        check("rst_achieve", 64'(score_achieve), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_row", 64'(Row1), 64'({{5{DK}}, 5'd0, {2{DK}}}));
        rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("run_score0", 64'(score_bcd), 64'h0);

        drain(3, 1'b1);
        pop_valid = 1'b1; pop_cnt = 4'd0; tick(); pop_valid = 1'b0;
        check("pop0_busy", 64'(busy), 64'h0);
        check("pop0_score", 64'(score_bcd), 64'h0003);
        drain(5, 1'b1);
        drain(5, 1'b1);
        check("carry_13", 64'(score_bcd), 64'h0013);
        drain(15, 1'b0);
        drain(15, 1'b0);
        drain(5, 1'b0);

        // Target: 48 + 5 stops at 50.
        pop_valid = 1'b1; pop_cnt = 4'd5; tick(); pop_valid = 1'b0;
        tick(); check("tgt_49", 64'(score_bcd), 64'h0049);
        tick(); check("tgt_50", 64'(score_bcd), 64'h0050);
        tick();
        check("tgt_achieve", 64'(score_achieve), 64'h1);
        check("tgt_busy", 64'(busy), 64'h0);
        check("tgt_hold", 64'(score_bcd), 64'h0050);
        pop_valid = 1'b1; pop_cnt = 4'd7; tick(); pop_valid = 1'b0;
        tick(); tick();
        check("done_pop_ign", 64'(score_bcd), 64'h0050);
        check("done_pop_busy", 64'(busy), 64'h0);
        check("done_row", 64'(Row1), 64'(row_exp(50)));

        // DONE -> IDLE -> RUN.
        start = 1'b1; tick(); start = 1'b0;
        check("idle_achieve", 64'(score_achieve), 64'h0);
        check("idle_score", 64'(score_bcd), 64'h0050);
        check("idle_row", 64'(Row1), 64'(row_exp(50)));
        start = 1'b1; tick(); start = 1'b0;
        check("rerun_score", 64'(score_bcd), 64'h0);
        tick();
        check("rerun_row", 64'(Row1), 64'(row_exp(0)));
        cur = 0;

        // start while running is ignored.
        pop_valid = 1'b1; pop_cnt = 4'd2; tick(); pop_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("start_in_run", 64'(score_bcd), 64'h0002);

        // game_over alone ends the round without achievement.
        game_over = 1'b1; tick();
        check("go_achieve", 64'(score_achieve), 64'h0);
        check("go_score", 64'(score_bcd), 64'h0002);
        game_over = 1'b0;
        pop_valid = 1'b1; pop_cnt = 4'd4; tick(); pop_valid = 1'b0; tick();
        check("go_done_hold", 64'(score_bcd), 64'h0002);
        check("go_done_busy", 64'(busy), 64'h0);

        // game_over coinciding with the target still counts as a win.
        start = 1'b1; tick(); tick(); start = 1'b0;
        check("rerun2_score", 64'(score_bcd), 64'h0);
        cur = 0;
        drain(15, 1'b0); drain(15, 1'b0); drain(15, 1'b0); drain(5, 1'b0);
        game_over = 1'b1; tick(); game_over = 1'b0;
        check("go_tgt_achieve", 64'(score_achieve), 64'h1);
        check("go_tgt_score", 64'(score_bcd), 64'h0050);

        // Reset mid-drain.
        start = 1'b1; tick(); tick(); start = 1'b0;
        pop_valid = 1'b1; pop_cnt = 4'd9; tick(); pop_valid = 1'b0;
        tick(); tick();
        check("mid_score", 64'(score_bcd), 64'h0002);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_score", 64'(score_bcd), 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_row", 64'(Row1), 64'({{5{DK}}, 5'd0, {2{DK}}}));
        pop_valid = 1'b1; pop_cnt = 4'd5; tick(); pop_valid = 1'b0;
        check("idle_pop_busy", 64'(busy), 64'h0);
        tick();
        check("idle_pop_score", 64'(score_bcd), 64'h0);

        // Pending saturation: five pops of 15 then drain, unreachable target.
        b_rst = 1'b0; tick();
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int t = 1; t <= 68; t++) exp_q.push_back(to_bcd(t - 1));
        for (int t = 1; t <= 68; t++) begin
            b_pop_valid = (t <= 5);
            b_pop_cnt   = 4'd15;
            tick();
            e = exp_q.pop_front();
            check("sat_score", 64'(b_score_bcd), 64'(e));
        end
        b_pop_valid = 1'b0;
        check("sat_busy_end", 64'(b_busy), 64'h0);

        // Score saturation at 9999 with pending still draining.
        b_pop_valid = 1'b1; b_pop_cnt = 4'd15;
        guard = 0;
        while (b_score_bcd != 16'h9999 && guard < 11000) begin
            tick();
            guard++;
        end
        check("reach_9999", 64'(b_score_bcd), 64'h9999);
        b_pop_valid = 1'b0;
        check("busy_at_9999", 64'(b_busy), 64'h1);
        guard = 0;
        while (b_busy && guard < 70) begin
            tick();
            guard++;
        end
        check("drain_at_9999", 64'(b_busy), 64'h0);
        check("hold_9999", 64'(b_score_bcd), 64'h9999);
        check("row_9999", 64'(b_Row1), 64'(row_exp(9999)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
